imem_debug_loader: RTL
======================

Name: imem_debug_loader

Overview:
- Initiator for the instruction-memory debug write/read port (A2/WD2/WE2/RD2) of the IF-ID stage instruction RAM.
- Takes a byte stream from a host link (UART receiver or similar) through a valid/ready handshake and packs it into 32-bit little-endian words.
- Writes each word to consecutive word addresses, reads it back and verifies it.
- Holds the CPU with cpu_hold while a load is in progress.

Parameters:
- TIMEOUT, 1000000, maximum idle cycles allowed between bytes while collecting before the load aborts.
- TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle load request; sampled only in IDLE.
- base_addr  input  32  byte address of the first word; bits [1:0] are ignored and treated as 0.
- word_count  input  16  number of words to load; latched on start.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- A2  output  32  debug port byte address.
- WD2  output  32  debug port write data.
- WE2  output  4  debug port byte write enables.
- RD2  input  32  debug port read data; synchronous, valid one cycle after A2 is presented.
- busy  output  1  a load is in progress.
- cpu_hold  output  1  keep the CPU stalled/reset; equal to busy.
- done  output  1  one-cycle pulse at the end of a load.
- timeout  output  1  sticky flag: the last load aborted on a timeout.
- err_cnt  output  16  readback mismatches in the last load; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE;
  - in_ready=0, A2=0, WD2=0, WE2=0;
  - busy=0, cpu_hold=0, done=0, timeout=0, err_cnt=0;
  - internal addr, word/byte counters and timeout counter all 0.
- Reset mid-load aborts the load immediately. No further WE2 is asserted after rst deasserts.
- State IDLE:
  - start=1 latches {base_addr[31:2],2'b00} into addr and word_count into remaining.
  - It also clears err_cnt and timeout.
  - Next state is COLLECT, or DONE if word_count==0.
- State COLLECT:
  - in_ready=1.
  - A byte transfers when in_valid && in_ready, and is placed at byte lane byte_idx (0 = bits [7:0], little-endian).
  - byte_idx increments on each transfer; the timeout counter clears on each transfer.
  - After the 4th byte, next state is WRITE.
  - With no transfer in a cycle, the timeout counter increments. On reaching TIMEOUT: set timeout=1, go to DONE, and discard the partial word.
- State WRITE (1 cycle):
  - A2=addr, WD2=word, WE2=4'b1111, in_ready=0.
  - Next state is READ.
- State READ (1 cycle):
  - A2=addr, WE2=0.
  - Next state is CHECK.
- State CHECK (1 cycle):
  - Compare RD2 with the held word; on mismatch, err_cnt increments (saturating).
  - addr += 4 (wraps modulo 2^32); remaining -= 1.
  - Next state is DONE if remaining becomes 0, else COLLECT with byte_idx=0.
- State DONE (1 cycle): done=1, busy still 1. Next state is IDLE.
- busy/cpu_hold is 1 in every state except IDLE.
- WE2 is nonzero only in WRITE.
- start outside IDLE is ignored.
- start and in_valid in the same IDLE cycle: the byte is not accepted (in_ready=0 in IDLE).
- Per-word minimum latency: 4 byte cycles + 3 cycles, giving 7 cycles per word at full byte rate.
- WD2 and A2 hold their last values outside WRITE/READ. Only WE2 qualifies a write.

Test Plan:
- Basic load: base_addr=0x100, word_count=2, bytes 78 56 34 12 EF BE AD DE streamed back-to-back, RAM model echoes writes. Required: writes of 0x12345678 @0x100 and 0xDEADBEEF @0x104, each with WE2=4'hF for exactly one cycle; done pulses 15 cycles after the first byte; err_cnt=0; busy high throughout.
- Unaligned base and zero count: base_addr=0x203 loads its first word at A2=0x200. Separately, word_count=0 gives done 2 cycles after start with no WE2 activity.
- Readback mismatch: the RAM model corrupts the second of 3 words. Required: err_cnt=1 at done; all 3 words still written.
- Backpressure/gaps: in_valid toggles with random gaps shorter than TIMEOUT (set TIMEOUT=16). Required: identical written data to the gap-free run; in_ready=0 during WRITE, READ and CHECK.
- Timeout: TIMEOUT=16, 6 bytes sent and then none. Required: exactly one write (word 0); timeout=1; done at 16 idle cycles after the 6th byte; return to IDLE.
- Async reset mid-load: assert rst=0 between clock edges during COLLECT of word 1. Required: all outputs 0 immediately; no write after release. A subsequent start loads correctly from a fresh base_addr.

Source files
------------

// File: rtl/imem_debug_loader.sv
// imem_debug_loader: receives a byte stream from the host link and packs it
// into little-endian words. Each word is written to the instruction RAM
// debug port, read back and compared. The CPU is held while a load runs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; CPU released
// COLLECT | accepting bytes into the word buffer; idle-timeout running
// WRITE   | word presented on A2/WD2 with WE2=4'hF
// READ    | A2 presented for readback; RD2 returns next cycle
// CHECK   | RD2 compared with held word; address/remaining advanced
// DONE    | one-cycle done pulse, then back to IDLE
module imem_debug_loader #(
  parameter int TIMEOUT = 1000000,
  parameter int TO_W    = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] A2,
  output logic [31:0] WD2,
  output logic [3:0]  WE2,
  input  logic [31:0] RD2,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        timeout,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_READ, S_CHECK, S_DONE
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_addr;
  logic [31:0]     r_word;
  logic [15:0]     r_remaining;
  logic [1:0]      r_byte_idx;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;
  logic [15:0]     r_err_cnt;
  logic [31:0]     r_a2;
  logic [31:0]     r_wd2;
  logic            w_xfer;
  logic            w_last_byte;
  logic            w_to_hit;
  logic            w_unused_base_lsbs;

  assign w_xfer      = in_valid && (r_state == S_COLLECT);
  assign w_last_byte = w_xfer && (r_byte_idx == 2'd3);
  // Abort on the idle cycle that would bring the counter up to TIMEOUT.
  assign w_to_hit    = (r_state == S_COLLECT) && !w_xfer && (r_to_cnt == TO_LAST);
  assign w_unused_base_lsbs = ^base_addr[1:0];

  // State register; async reset drops straight to IDLE, killing any write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = (word_count == 16'd0) ? S_DONE : S_COLLECT;
      S_COLLECT: begin
        if (w_last_byte)   w_next = S_WRITE;
        else if (w_to_hit) w_next = S_DONE;
      end
      S_WRITE:   w_next = S_READ;
      S_READ:    w_next = S_CHECK;
      S_CHECK:   w_next = (r_remaining == 16'd1) ? S_DONE : S_COLLECT;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = 1'b0;
    WE2      = 4'h0;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      S_IDLE:    busy     = 1'b0;
      S_COLLECT: in_ready = 1'b1;
      S_WRITE:   WE2      = 4'hF;
      S_DONE:    done     = 1'b1;
      default:   ;
    endcase
  end

  assign cpu_hold = busy;
  assign A2       = r_a2;
  assign WD2      = r_wd2;
  assign timeout  = r_timeout;
  assign err_cnt  = r_err_cnt;

  // Datapath: byte packing, address/count bookkeeping, timeout and readback check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_word      <= '0;
      r_remaining <= '0;
      r_byte_idx  <= '0;
      r_to_cnt    <= '0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_a2        <= '0;
      r_wd2       <= '0;
    end else begin
      if (r_state != S_COLLECT) begin
        r_byte_idx <= '0;
        r_to_cnt   <= '0;
      end
      case (r_state)
        S_IDLE: if (start) begin
          r_addr      <= {base_addr[31:2], 2'b00};
          r_remaining <= word_count;
          r_err_cnt   <= '0;
          r_timeout   <= 1'b0;
        end
        S_COLLECT: begin
          if (w_xfer) begin
            case (r_byte_idx)
              2'd0:    r_word[7:0]   <= in_data;
              2'd1:    r_word[15:8]  <= in_data;
              2'd2:    r_word[23:16] <= in_data;
              default: r_word[31:24] <= in_data;
            endcase
            r_byte_idx <= r_byte_idx + 2'd1;
            r_to_cnt   <= '0;
            if (w_last_byte) begin
              r_a2  <= r_addr;
              r_wd2 <= {in_data, r_word[23:0]};
            end
          end else if (w_to_hit) begin
            r_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if ((RD2 != r_wd2) && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
          r_addr      <= r_addr + 32'd4;
          r_remaining <= r_remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
